// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: request/response bundle between decode/bypass logic and the ALU.
// master = requester (execute stage), slave = pipelined_alu.
interface pipelined_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [4:0]         ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;
  logic               div_by_zero;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, div_by_zero
  );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered ALU with valid/ready handshake. Define PIPELINED_ALU_MULDIV_EN
// to build the iterative signed MUL/DIV datapath; otherwise opcodes 6/7 decode as ADD.
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic           clock,
  input  logic           reset_n,
  pipelined_alu_if.slave bus
);
  // Opcode 0 and every undecoded value fall through to ADD.
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

`ifdef PIPELINED_ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;
  localparam int         CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t state, state_next;

  logic [WIDTH-1:0]   a, b;
  logic [4:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic               in_ready, out_valid, accept;

  assign a      = bus.data_operandA;
  assign b      = bus.data_operandB;
  assign op     = bus.ctrl_ALUopcode;
  assign shamt  = bus.ctrl_shiftamt;
  assign accept = bus.in_valid && in_ready;

  // Single-cycle datapath.
  logic [WIDTH-1:0] add_sum, sub_diff, sc_result;
  logic             add_ovf, sub_ovf, sc_ovf;

  assign add_sum  = a + b;
  assign sub_diff = a - b;
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sc_result = add_sum;
    sc_ovf    = add_ovf;
    case (op)
      OP_SUB: begin sc_result = sub_diff; sc_ovf = sub_ovf; end
      OP_AND: begin sc_result = a & b;    sc_ovf = 1'b0;    end
      OP_OR:  begin sc_result = a | b;    sc_ovf = 1'b0;    end
      OP_SLL: begin sc_result = a << shamt; sc_ovf = 1'b0;  end
      OP_SRA: begin sc_result = $signed(a) >>> shamt; sc_ovf = 1'b0; end
      default: ;
    endcase
  end

`ifdef PIPELINED_ALU_MULDIV_EN
  // Iterative datapath: shift-add multiply and restoring divide, both on magnitudes.
  logic               is_muldiv;
  logic [CNT_W-1:0]   cnt;
  logic               md_div, md_neg, md_dbz, md_div_ovf;
  logic [2*WIDTH-1:0] acc, mcand, acc_step, prod;
  logic [WIDTH-1:0]   mplier, rem, quo, dvsr, abs_a, abs_b;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   rem_step, quo_step, md_result;
  logic               md_ovf_fin;

  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign abs_a     = a[WIDTH-1] ? -a : a;
  assign abs_b     = b[WIDTH-1] ? -b : b;

  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : '0);
    prod     = md_neg ? -acc_step : acc_step;
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, dvsr};
    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    rem_step = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
    md_result  = prod[WIDTH-1:0];
    md_ovf_fin = ~(&prod[2*WIDTH-1:WIDTH-1]) && (|prod[2*WIDTH-1:WIDTH-1]);
    if (md_div) begin
      md_result  = md_dbz ? '1 : (md_neg ? -quo_step : quo_step);
      md_ovf_fin = md_div_ovf;
    end
  end
`endif

  // FSM: state register plus next-state logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) begin
`ifdef PIPELINED_ALU_MULDIV_EN
        state_next = is_muldiv ? S_BUSY : S_DONE;
`else
        state_next = S_DONE;
`endif
      end
`ifdef PIPELINED_ALU_MULDIV_EN
      S_BUSY: if (cnt == CNT_LAST) state_next = S_DONE;
`endif
      S_DONE: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Result and flag registers, loaded at accept or at the last iteration.
  logic [WIDTH-1:0] result_q;
  logic             ne_q, lt_q, ovf_q, dbz_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all state here is a handful of flops, so every one is reset for a clean abort.
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef PIPELINED_ALU_MULDIV_EN
      cnt        <= '0;
      md_div     <= 1'b0;
      md_neg     <= 1'b0;
      md_dbz     <= 1'b0;
      md_div_ovf <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
`endif
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ne_q <= (a != b);
      lt_q <= ($signed(a) < $signed(b));
`ifdef PIPELINED_ALU_MULDIV_EN
      if (is_muldiv) begin
        cnt        <= '0;
        md_div     <= (op == OP_DIV);
        md_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
        md_dbz     <= (op == OP_DIV) && (b == '0);
        md_div_ovf <= (a == MIN_VAL) && (b == '1);
        acc        <= '0;
        mcand      <= {{WIDTH{1'b0}}, abs_a};
        mplier     <= abs_b;
        rem        <= '0;
        quo        <= abs_a;
        dvsr       <= abs_b;
      end else begin
        result_q <= sc_result;
        ovf_q    <= sc_ovf;
        dbz_q    <= 1'b0;
      end
`else
      result_q <= sc_result;
      ovf_q    <= sc_ovf;
      dbz_q    <= 1'b0;
`endif
    end
`ifdef PIPELINED_ALU_MULDIV_EN
    else if (state == S_BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_step;
      quo    <= quo_step;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        result_q <= md_result;
        ovf_q    <= md_ovf_fin;
        dbz_q    <= md_dbz;
        cnt      <= '0;
      end
    end
`endif
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.data_result = result_q;
  assign bus.isNotEqual  = ne_q;
  assign bus.isLessThan  = lt_q;
  assign bus.overflow    = ovf_q;
`ifdef PIPELINED_ALU_MULDIV_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: scoreboard bench for pipelined_alu (WIDTH=32); expectations follow
// PIPELINED_ALU_MULDIV_EN so the same bench serves both builds.
module tb_pipelined_alu;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] result;
    logic [3:0]   flags;   // {ne, lt, ovf, dbz}
    int           lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  pipelined_alu_if #(.WIDTH(W)) bus ();

  pipelined_alu #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Reference model built on 64-bit signed arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] sh);
    exp_t e;
    logic signed [63:0] sa, sb, full;
    logic ovf, dbz;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ovf = 1'b0;
    dbz = 1'b0;
    e.lat = 1;
    case (op)
      5'd1: begin full = sa - sb; e.result = full[W-1:0];
                  ovf = !((full[63:W-1] == '0) || (full[63:W-1] == '1)); end
      5'd2: e.result = a & b;
      5'd3: e.result = a | b;
      5'd4: e.result = a << sh;
      5'd5: begin full = sa >>> sh; e.result = full[W-1:0]; end
`ifdef PIPELINED_ALU_MULDIV_EN
      5'd6: begin full = sa * sb; e.result = full[W-1:0]; e.lat = W + 1;
                  ovf = !((full[63:W-1] == '0) || (full[63:W-1] == '1)); end
      5'd7: begin
        e.lat = W + 1;
        if (b == '0) begin e.result = '1; dbz = 1'b1; end
        else if (a == 32'h8000_0000 && b == '1) begin e.result = 32'h8000_0000; ovf = 1'b1; end
        else begin full = sa / sb; e.result = full[W-1:0]; end
      end
`endif
      default: begin full = sa + sb; e.result = full[W-1:0];
                     ovf = !((full[63:W-1] == '0) || (full[63:W-1] == '1)); end
    endcase
    e.flags = {a != b, sa < sb, ovf, dbz};
    return e;
  endfunction

  // Issue one request, then pop the scoreboard when the result appears; hold
  // out_ready low for 'hold' cycles first to exercise backpressure.
  task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input int hold);
    exp_t e;
    int   n;
    sb_q.push_back(model(op, a, b, sh));
    @(negedge clock);
    n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clock); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL %s in_ready: got 0, want 1 within 200 cycles", name);
      void'(sb_q.pop_front());
      return;
    end
    bus.in_valid = 1'b1;
    bus.ctrl_ALUopcode = op;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_shiftamt = sh;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    bus.ctrl_ALUopcode = 5'($urandom);
    bus.ctrl_shiftamt = 5'($urandom);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.out_valid && n < 200);
    e = sb_q.pop_front();
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL %s out_valid: got 0, want 1 within 200 cycles", name);
      return;
    end
    checks++;
    if (n !== e.lat) begin
      errors++; $display("FAIL %s latency: got %0d, want %0d", name, n, e.lat);
    end
    checks++;
    if (bus.data_result !== e.result) begin
      errors++; $display("FAIL %s result: got %h, want %h", name, bus.data_result, e.result);
    end
    checks++;
    if ({bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero} !== e.flags) begin
      errors++;
      $display("FAIL %s flags{ne,lt,ovf,dbz}: got %b, want %b", name,
               {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero}, e.flags);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_result !== e.result) begin
        errors++;
        $display("FAIL %s hold[%0d]: got valid=%b ready=%b result=%h, want 1 0 %h",
                 name, i, bus.out_valid, bus.in_ready, bus.data_result, e.result);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_ALUopcode = '0;
    bus.ctrl_shiftamt = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset handshake: got ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.data_result !== '0 ||
        {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero} !== 4'b0) begin
      errors++;
      $display("FAIL reset outputs: got result=%h flags=%b, want 0 0000", bus.data_result,
               {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.ctrl_ALUopcode = 5'd6;
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd1000;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.data_result !== '0 ||
        {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero} !== 4'b0) begin
      errors++;
      $display("FAIL mid_busy_reset: got valid=%b ready=%b result=%h flags=%b, want 0 1 0 0000",
               bus.out_valid, bus.in_ready, bus.data_result,
               {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.div_by_zero});
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_op("add_after_reset", 5'd0, 32'd2, 32'd3, 5'd0, 0);
  endtask

  task automatic test_add_sub();
    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
    run_op("sub_zero", 5'd1, 32'd5, 32'd5, 5'd0, 0);
    run_op("sub_ovf", 5'd1, 32'h8000_0000, 32'd1, 5'd0, 0);
    run_op("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 0);
    run_op("or", 5'd3, 32'hF000_0001, 32'h000F_0010, 5'd0, 0);
  endtask

  task automatic test_shifts();
    run_op("sll31", 5'd4, 32'h0000_0001, 32'd0, 5'd31, 0);
    run_op("sra4_hold", 5'd5, 32'h8000_0000, 32'd7, 5'd4, 5);
  endtask

  task automatic test_mul();
    run_op("mul_neg", 5'd6, -32'sd7, 32'd6, 5'd0, 0);
    run_op("mul_ovf", 5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    run_op("mul_min", 5'd6, 32'h8000_0000, 32'h8000_0000, 5'd0, 0);
  endtask

  task automatic test_div();
    run_op("div_neg", 5'd7, -32'sd7, 32'd2, 5'd0, 0);
    run_op("div_min", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    run_op("div_zero", 5'd7, 32'd9, 32'd0, 5'd0, 3);
    run_op("div_pos", 5'd7, 32'd100, -32'sd7, 5'd0, 0);
  endtask

  task automatic test_opcode_alias();
    run_op("op6_4_5", 5'd6, 32'd4, 32'd5, 5'd0, 0);
    run_op("op12_alias", 5'd12, 32'd4, 32'd5, 5'd0, 0);
    run_op("op31_alias", 5'd31, 32'hFFFF_FFFF, 32'd2, 5'd0, 0);
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.ctrl_ALUopcode = 5'd0;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd23;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        done_cnt++;
        checks++;
        if (bus.data_result !== 32'd123) begin
          errors++; $display("FAIL b2b result: got %h, want %h", bus.data_result, 32'd123);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    checks++;
    if (done_cnt !== 5) begin
      errors++; $display("FAIL b2b throughput: got %0d results in 10 cycles, want 5", done_cnt);
    end
    for (int i = 0; i < 8; i++)
      run_op("random", 5'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_add_sub();
    test_shifts();
    test_mul();
    test_div();
    test_opcode_alias();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, handshaked successor to the processor's single-cycle combinational ALU. It keeps the ADD/SUB/AND/OR/SLL/SRA opcode map and comparison flags and registers all results. It adds iterative signed multiply and divide, with a valid/ready interface so the execute stage can stall on long operations. It sits between the decode/bypass logic and the execute/memory pipeline register.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 4, power of two).
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `data_operandA` in WIDTH: operand A, two's complement.
- `data_operandB` in WIDTH: operand B, two's complement.
- `ctrl_ALUopcode` in 5: operation select.
- `ctrl_shiftamt` in SHAMT_W: shift amount.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: consumer takes the result.
- `data_result` out WIDTH: registered result.
- `isNotEqual` out 1: A != B, captured at accept.
- `isLessThan` out 1: signed A < B, captured at accept.
- `overflow` out 1: signed overflow of the operation.
- `div_by_zero` out 1: DIV issued with B == 0.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR.
  - 4 SLL (A << shamt); 5 SRA (A >>> shamt, sign fill).
  - 6 MUL (low WIDTH bits of signed A×B).
  - 7 DIV (signed quotient, truncated toward zero).
  - All other opcodes behave as ADD.
- FSM states:
  - IDLE: `in_ready`=1. A transfer occurs when `in_valid && in_ready`; operands, opcode, shamt and compare flags are captured at that edge. Later operand changes are ignored.
  - On accept, opcodes 0–5 and 8–31 → DONE with the result registered.
  - On accept, MUL/DIV → BUSY with the iteration counter at 0.
  - BUSY: one shift-add (MUL) or one restoring-divide step (DIV) on magnitudes per cycle. After WIDTH steps, sign correction and flags are applied → DONE.
  - DONE: `out_valid`=1; result and flags are held stable until `out_ready`=1, then → IDLE.
- `in_ready` is 0 in BUSY and DONE; there is no overlap of requests.
- Overflow rules:
  - ADD/SUB: signed overflow (operand signs vs. result sign).
  - MUL: set when the full 2·WIDTH signed product does not sign-extend from bit WIDTH-1.
  - DIV: set only for MIN/−1; the result is MIN.
  - All other opcodes: 0.
- Divide by zero: result = all ones, `div_by_zero`=1, `overflow`=0; all WIDTH cycles are still spent.
- `div_by_zero` is 0 for every non-DIV opcode.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, counter 0, `in_ready`=1, `out_valid`=0. `data_result`, `isNotEqual`, `isLessThan`, `overflow` and `div_by_zero` are all 0.
- Latency, accept edge t to first `out_valid`=1 cycle:
  - Single-cycle opcodes: t+1.
  - MUL/DIV: t+1+WIDTH.
- Peak throughput is one operation per 2 cycles, when `out_ready` is held at 1.
- Backpressure: with `out_ready`=0, DONE is held indefinitely and all outputs stay unchanged.
- `reset_n` asserted in BUSY or DONE aborts the operation immediately; the in-flight result is discarded.
- `in_valid` in BUSY or DONE has no effect; the requester must hold it until it sees `in_ready`.

## Configuration
- `PIPELINED_ALU_MULDIV_EN` defined: MUL and DIV are implemented as described.
- Not defined:
  - No BUSY state, counter or multiply/divide datapath is built.
  - Opcodes 6 and 7 decode as ADD (single-cycle).
  - `div_by_zero` is tied to 0.

## Test plan
- Test WIDTH=32 unless noted.
- Reset mid-BUSY: MUL 1000×1000; assert `reset_n`=0 at t+10. Expect `out_valid`=0, `in_ready`=1, outputs 0 asynchronously. A fresh ADD 2+3 then returns 5 at t'+1.
- ADD/SUB: ADD 0x7FFFFFFF+1 → 0x80000000, `overflow`=1, `isLessThan`=0, `isNotEqual`=1. SUB 5−5 → 0, `isNotEqual`=0, `overflow`=0; both valid one cycle after accept.
- Shifts: SLL 0x00000001 by 31 → 0x80000000. SRA 0x80000000 by 4 → 0xF8000000. With `out_ready`=0 for 5 cycles, the result is held and `in_ready`=0 throughout.
- MUL: −7×6 → 0xFFFFFFD6, `overflow`=0, `out_valid` exactly 33 cycles after accept. 0x00010000×0x00010000 → 0, `overflow`=1.
- DIV:
  - −7/2 → 0xFFFFFFFD.
  - 0x80000000/−1 → 0x80000000, `overflow`=1.
  - 9/0 → 0xFFFFFFFF, `div_by_zero`=1.
  - Each at 33 cycles after accept.
- Macro undefined, opcode 6 with A=4, B=5: result 9 at t+1, `div_by_zero`=0; opcode 12 also yields 9.
